// File: rtl/credit_bp_rx_pkg.sv
// rtl/credit_bp_rx_pkg.sv - shared link defaults and flit layout for the credit tx/rx pair
package credit_bp_rx_pkg;

    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_D_W           = 8;
    localparam int DEFAULT_A_W           = 4;
    localparam int DEFAULT_VC_FIFO_DEPTH = 4;
    localparam int DEFAULT_FLIT_W        = DEFAULT_A_W + DEFAULT_D_W + 1;

    // Same packing as the transmitter's i_d so both link ends are bit-compatible
    typedef struct packed {
        logic                   last;
        logic [DEFAULT_A_W-1:0] addr;
        logic [DEFAULT_D_W-1:0] data;
    } flit_t;

endpackage

// File: rtl/noc_if.sv
// rtl/noc_if.sv - credit link between credit_bp_tx and credit_bp_rx
interface noc_if
    import credit_bp_rx_pkg::*;
#(
    parameter int VC_W = DEFAULT_VC_W,
    parameter int D_W  = DEFAULT_D_W,
    parameter int A_W  = DEFAULT_A_W
) ();

    typedef struct packed {
        logic [A_W-1:0] addr;
    } routeinfo_t;

    typedef struct packed {
        logic [D_W-1:0] data;
        logic           last;
    } payload_t;

    typedef struct packed {
        routeinfo_t routeinfo;
        payload_t   payload;
    } packet_t;

    logic [VC_W-1:0] vc_target;
    packet_t         packet;
    logic [VC_W-1:0] vc_credit_gnt;

    modport sender   (output vc_target, output packet, input  vc_credit_gnt);
    modport receiver (input  vc_target, input  packet, output vc_credit_gnt);

endinterface

// File: rtl/credit_bp_rx_fifo.sv
// rtl/credit_bp_rx_fifo.sv - single-VC show-ahead FIFO holding DEPTH-1 flits
module credit_bp_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_rd,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PTR_W = $clog2(DEPTH - 1);
    localparam int CNT_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH - 1);

    logic [W-1:0]     r_mem [DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr_ok;
    logic             w_rd;

    assign o_full  = (r_count == CNT_MAX);
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    // A full FIFO may still accept a write in the cycle its head leaves
    assign w_wr_ok = i_wr & (~o_full | i_rd);
    assign w_rd    = i_rd & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr_ok, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_count <= CNT_MAX) else $error("credit_bp_rx_fifo: count above DEPTH-1");
        end
    end
`endif

endmodule

// File: rtl/credit_bp_rx.sv
// rtl/credit_bp_rx.sv - credit link receiver: per-VC FIFOs, DVR outputs, registered credit return
// Optional zero-latency empty-FIFO bypass under CREDIT_BP_RX_BYPASS_EN.
module credit_bp_rx
    import credit_bp_rx_pkg::*;
#(
    parameter int VC_W  = DEFAULT_VC_W,
    parameter int D_W   = DEFAULT_D_W,
    parameter int A_W   = DEFAULT_A_W,
    parameter int DEPTH = DEFAULT_VC_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    noc_if.receiver                       from_tx,
    output logic [VC_W-1:0]               o_v,
    output logic [VC_W*(A_W+D_W+1)-1:0]   o_d,
    input  logic [VC_W-1:0]               i_b
);

    localparam int FW = A_W + D_W + 1;

    logic [FW-1:0]   w_pkt;
    logic [VC_W-1:0] w_deq;
    logic [VC_W-1:0] r_gnt;

    assign w_pkt = {from_tx.packet.payload.last, from_tx.packet.routeinfo.addr,
                    from_tx.packet.payload.data};
    assign from_tx.vc_credit_gnt = r_gnt;

    genvar ii;
    generate
        for (ii = 0; ii < VC_W; ii++) begin : g_vc
            logic          w_empty;
            logic          w_full;
            logic          w_rd;
            logic          w_wr;
            logic          w_byp;
            logic [FW-1:0] w_head;

`ifdef CREDIT_BP_RX_BYPASS_EN
            assign w_byp = w_empty & from_tx.vc_target[ii];
            assign o_d[ii*FW +: FW] = w_empty ? w_pkt : w_head;
`else
            assign w_byp = 1'b0;
            assign o_d[ii*FW +: FW] = w_head;
`endif
            assign o_v[ii]   = ~w_empty | w_byp;
            assign w_deq[ii] = o_v[ii] & ~i_b[ii];
            assign w_rd      = w_deq[ii] & ~w_empty;
            // A bypassed flit that is taken immediately never touches storage
            assign w_wr      = from_tx.vc_target[ii] & ~(w_byp & ~i_b[ii]) & (~w_full | w_rd);

            credit_bp_rx_fifo #(
                .DEPTH (DEPTH),
                .W     (FW)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_wr    (w_wr),
                .i_wdata (w_pkt),
                .i_rd    (w_rd),
                .o_rdata (w_head),
                .o_full  (w_full),
                .o_empty (w_empty)
            );

`ifdef SIMULATION
            logic          r_hold;
            logic [FW-1:0] r_hold_d;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    assert (!(from_tx.vc_target[ii] && w_full && !w_rd))
                        else $error("credit_bp_rx: overflow on VC %0d", ii);
                end
                if (r_hold) begin
                    assert (o_d[ii*FW +: FW] == r_hold_d)
                        else $error("credit_bp_rx: o_d changed under backpressure on VC %0d", ii);
                end
                r_hold   <= ~rst & o_v[ii] & i_b[ii];
                r_hold_d <= o_d[ii*FW +: FW];
            end
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt <= '0;
        end else begin
            r_gnt <= w_deq;
        end
    end

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(from_tx.vc_target)) else $error("credit_bp_rx: vc_target not onehot0");
            assert (!$isunknown(o_v)) else $error("credit_bp_rx: o_v unknown");
            assert (!$isunknown(r_gnt)) else $error("credit_bp_rx: vc_credit_gnt unknown");
        end
    end
`endif

endmodule

// File: doc/credit_bp_rx.md
Name: credit_bp_rx

Overview:
Receiver half of the credit-based backpressure link. It accepts flits from an upstream credit transmitter over noc_if, buffers them in one FIFO per VC, and presents them to the downstream switch input as per-VC DVR streams. It returns one credit per VC each time a flit leaves that VC's FIFO. It sits at each switch input port, directly downstream of the link's credit transmitter.

Parameters:
VC_W, DEFAULT_VC_W, number of virtual channels
D_W, DEFAULT_D_W, payload data width
A_W, DEFAULT_A_W, address width
DEPTH, DEFAULT_VC_FIFO_DEPTH, credit depth; each FIFO holds DEPTH-1 flits to match the transmitter's DEPTH-1 initial credits; DEPTH >= 3

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
from_tx  noc_if.receiver  -  vc_target[VC_W] (onehot0 arrival), packet {routeinfo.addr, payload.data, payload.last}, vc_credit_gnt[VC_W] (driven by this block)
o_v  output  VC_W  per-VC valid to the switch
o_d  output  VC_W*(A_W+D_W+1)  per-VC flit; slice ii = {last, addr, data}, with data in the LSBs
i_b  input  VC_W  per-VC backpressure from the switch

Behaviour:
- Flit format: {last, addr, data}, packed the same way as the transmitter's i_d, so the two link ends are bit-compatible.
- Enqueue: on cycle t, if from_tx.vc_target[ii] is high, the packet is written into FIFO ii.
  - The flit is visible on o_v[ii]/o_d[ii] at t+1 (registered storage, show-ahead read).
- Dequeue: a flit leaves FIFO ii when o_v[ii] & !i_b[ii].
  - o_d[ii] must hold stable while o_v[ii] & i_b[ii].
  - o_v[ii] = (count_ii != 0).
  - o_d[ii] is don't-care when o_v[ii] is low.
- Credit return: from_tx.vc_credit_gnt[ii] is registered. It is high on cycle t+1 exactly when a dequeue from VC ii occurred on cycle t.
  - At most one credit per VC per cycle.
  - Reset value of the grant register is 0.
- Per-VC state:
  - wr_ptr and rd_ptr, each ranging 0..DEPTH-2 and wrapping explicitly from DEPTH-2 back to 0 (capacity is not a power of two in general).
  - count, width $clog2(DEPTH), ranging 0..DEPTH-1.
- Simultaneous enqueue and dequeue on the same VC: count is unchanged and both pointers advance. This is legal when the FIFO is full (the dequeue frees the slot) and when it holds one entry.
- Full (count == DEPTH-1) with enqueue and no dequeue is a protocol violation.
  - The write is dropped and count saturates.
  - Simulation assertion fires.
- Empty with dequeue is impossible, because o_v is low.
- Reset, including mid-operation: all counts, pointers and grant registers clear; o_v = 0, vc_credit_gnt = 0; buffered flits are discarded.
  - The transmitter resets its credits to DEPTH-1 on the same edge, so both ends stay consistent only when rst is shared.
  - Storage is not reset.
- VCs are fully independent; there is no cross-VC arbitration inside this block.
- Assertions, under SIMULATION:
  - No overflow.
  - count <= DEPTH-1.
  - vc_target is onehot0.
  - o_v and vc_credit_gnt are never X out of reset.
  - o_d[ii] is stable while o_v[ii] & i_b[ii].

Optional Feature:
Macro: CREDIT_BP_RX_BYPASS_EN
- Defined:
  - When FIFO ii is empty and vc_target[ii] is high, o_v[ii] is asserted in the same cycle with o_d[ii] driven combinationally from from_tx.packet.
  - If additionally !i_b[ii], the flit is consumed without being written, and the credit returns the next cycle.
  - If i_b[ii] is high, the flit is written normally.
  - Zero-cycle buffer latency.
- Undefined: the 1-cycle minimum latency described above. The credit/ordering semantics are identical.

Decomposition:
- common_pkg: add a flit-width constant (A_W+D_W+1 via default params) and a packed flit struct typedef shared with credit_bp_tx. Existing DEFAULT_VC_FIFO_DEPTH is reused.
- Sub-module credit_bp_rx_fifo: a single-VC FIFO with DEPTH-1 entries, count, and full/empty flags, instantiated VC_W times in a generate loop.
- The credit register and bypass mux live in the top module.

Test Plan:
1. VC_W=2, DEPTH=4; send flit 0xA5 (addr 3, last 1) on VC0 with i_b=0 -> o_v[0]=1 next cycle with o_d[0]={1,3,0xA5}; vc_credit_gnt[0]=1 exactly one cycle after that; VC1 untouched.
2. i_b[0]=1; send 3 flits on VC0 -> count reaches 3 and holds; drop i_b -> flits emerge in order over 3 consecutive cycles; 3 credit pulses follow, each lagging its dequeue by 1 cycle.
3. VC0 full (3 flits) and i_b[0]=0; new flit arrives on the same cycle as a dequeue -> no overflow, count stays 3, order preserved.
4. Interleave arrivals VC0, VC1, VC0 with i_b=2'b01 -> VC1 drains immediately, VC0 holds 2 flits; total credits returned per VC equals flits dequeued per VC.
5. Back-to-back with credit_bp_tx (DEPTH=4), random i_b -> no assertion fires; transmitter credits are back at 3 after draining.
6. Assert rst with 2 flits buffered -> next cycle o_v=0 and vc_credit_gnt=0; new traffic flows normally afterwards. With CREDIT_BP_RX_BYPASS_EN: a flit arriving on an empty VC with i_b=0 -> o_v same cycle, credit next cycle.
